vram_arbiter: RTL

- Single-port VRAM arbiter sharing one synchronous-read RAM (registered read, 1-cycle latency) between the uPD7801 CPU bus and the video fetch engine.
- Video fetch has priority. A streak limit guarantees the CPU a slot.
- The CPU is stalled through WAITB until its access completes.
- Sits between the CPU bus decode (VRAM chip select from A[15]=0) and the VRAM macro.

---
 rtl/vram_arbiter_if.sv | 49 ++++
 rtl/vram_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Purpose: bundles the CPU bus, video fetch and VRAM macro signals of the VRAM arbiter.
// Latency: none, wiring only.
// Backpressure: CPU side stalls on CPU_WAITB low; the video side sees it as VID_ACK being withheld.
//
// Ports (members):
//   CPU_nCS/CPU_RDB/CPU_WRB/CPU_A/CPU_DI -> arbiter   CPU_DO/CPU_WAITB <- arbiter
//   VID_REQ/VID_A -> arbiter                        VID_ACK/VID_VALID/VID_DO <- arbiter
//   RAM_DO -> arbiter                               RAM_A/RAM_DI/RAM_nCE/RAM_nWE <- arbiter
// slave  = arbiter side, master = everything around it (CPU decode, video engine, RAM macro).
interface vram_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          CPU_nCS;
  logic          CPU_RDB;
  logic          CPU_WRB;
  logic [AW-1:0] CPU_A;
  logic [DW-1:0] CPU_DI;
  logic [DW-1:0] CPU_DO;
  logic          CPU_WAITB;
  logic          VID_REQ;
  logic [AW-1:0] VID_A;
  logic          VID_ACK;
  logic          VID_VALID;
  logic [DW-1:0] VID_DO;
  logic [AW-1:0] RAM_A;
  logic [DW-1:0] RAM_DI;
  logic [DW-1:0] RAM_DO;
  logic          RAM_nCE;
  logic          RAM_nWE;

  modport slave (
    input  CPU_nCS, CPU_RDB, CPU_WRB, CPU_A, CPU_DI,
    output CPU_DO, CPU_WAITB,
    input  VID_REQ, VID_A,
    output VID_ACK, VID_VALID, VID_DO,
    output RAM_A, RAM_DI, RAM_nCE, RAM_nWE,
    input  RAM_DO
  );

  modport master (
    output CPU_nCS, CPU_RDB, CPU_WRB, CPU_A, CPU_DI,
    input  CPU_DO, CPU_WAITB,
    output VID_REQ, VID_A,
    input  VID_ACK, VID_VALID, VID_DO,
    input  RAM_A, RAM_DI, RAM_nCE, RAM_nWE,
    output RAM_DO
  );
endinterface

// File: rtl/vram_arbiter.sv
// Purpose: single-port VRAM arbiter, video fetch first, CPU guaranteed a slot after MAXVID video grants.
// Latency: RAM command same cycle as grant; video data/valid 1 cycle later, CPU read data 2 cycles after grant.
// Backpressure: CPU held on CPU_WAITB low until its access completes; video stalls by not seeing VID_ACK.
//
// Ports: CLK (clock), RES (sync active-high reset), bus (vram_arbiter_if.slave: CPU bus,
// video fetch request/return, VRAM macro command and read data).
module vram_arbiter #(
  parameter int AW     = 11,
  parameter int DW     = 8,
  parameter int MAXVID = 4
) (
  input  logic           CLK,
  input  logic           RES,
  vram_arbiter_if.slave  bus
);

  localparam logic [3:0] MAXV = 4'(MAXVID);

  logic          cpu_req;
  logic          cpu_wr;
  logic          cpu_pend;
  logic          vid_gnt;
  logic          cpu_gnt;

  logic [3:0]    streak_q,          streak_d;
  logic          cpu_done_q,        cpu_done_d;
  logic          cpu_rd_inflight_q, cpu_rd_inflight_d;
  logic [DW-1:0] cpu_do_q,          cpu_do_d;
  logic          vid_valid_q,       vid_valid_d;
  logic [AW-1:0] ram_a_q,           ram_a_d;

  // Grant for the current slot. Nothing is granted while RES is high so the
  // RAM sees no command during reset.
  always_comb begin
    cpu_req  = ~bus.CPU_nCS & (~bus.CPU_RDB | ~bus.CPU_WRB);
    cpu_wr   = ~bus.CPU_WRB;
    // cpu_done/inflight mask a request that is already served or in the RAM pipe.
    cpu_pend = cpu_req & ~cpu_done_q & ~cpu_rd_inflight_q;
    vid_gnt  = ~RES & bus.VID_REQ & (~cpu_pend | (streak_q < MAXV));
    cpu_gnt  = ~RES & cpu_pend & ~vid_gnt;
  end

  always_comb begin
    streak_d          = streak_q;
    cpu_done_d        = cpu_done_q;
    cpu_rd_inflight_d = cpu_gnt & ~cpu_wr;
    cpu_do_d          = cpu_do_q;
    vid_valid_d       = vid_gnt;
    ram_a_d           = ram_a_q;

    // The video streak only matters while the CPU is waiting.
    if (cpu_gnt || !cpu_pend) begin
      streak_d = 4'd0;
    end else if (vid_gnt && (streak_q < MAXV)) begin
      streak_d = streak_q + 4'd1;
    end

    // Read data lands the cycle after the grant, even if the strobe was
    // already released; cpu_done then only sticks while the strobe is held.
    if (cpu_rd_inflight_q) begin
      cpu_do_d = bus.RAM_DO;
    end

    if (!cpu_req) begin
      cpu_done_d = 1'b0;
    end else if ((cpu_gnt && cpu_wr) || cpu_rd_inflight_q) begin
      cpu_done_d = 1'b1;
    end

    // The address bus holds its last value through idle slots.
    if (vid_gnt) begin
      ram_a_d = bus.VID_A;
    end else if (cpu_gnt) begin
      ram_a_d = bus.CPU_A;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      streak_q          <= 4'd0;
      cpu_done_q        <= 1'b0;
      cpu_rd_inflight_q <= 1'b0;
      cpu_do_q          <= '0;
      vid_valid_q       <= 1'b0;
      ram_a_q           <= '0;
    end else begin
      streak_q          <= streak_d;
      cpu_done_q        <= cpu_done_d;
      cpu_rd_inflight_q <= cpu_rd_inflight_d;
      cpu_do_q          <= cpu_do_d;
      vid_valid_q       <= vid_valid_d;
      ram_a_q           <= ram_a_d;
    end
  end

  assign bus.RAM_A     = ram_a_d;
  assign bus.RAM_DI    = bus.CPU_DI;
  assign bus.RAM_nCE   = ~(vid_gnt | cpu_gnt);
  assign bus.RAM_nWE   = ~(cpu_gnt & cpu_wr);
  assign bus.VID_ACK   = vid_gnt;
  assign bus.CPU_WAITB = ~(cpu_req & ~cpu_done_q);
  assign bus.CPU_DO    = cpu_do_q;

  // The RAM's own output register is the video data stage. A read still in
  // the RAM pipe when RES arrives must not be reported, hence the RES mask.
  assign bus.VID_VALID = vid_valid_q & ~RES;
  assign bus.VID_DO    = (vid_valid_q & ~RES) ? bus.RAM_DO : '0;

endmodule
